router_pkt_reader: RTL and testbench
====================================

Name: router_pkt_reader

Overview:
- Egress-side consumer for one router output FIFO.
- Drains the FIFO byte by byte by generating read_enb, and reframes the bytes into packets (header, payload, parity) using the header length field.
- Presents each byte to the destination with a valid/ready handshake.
- Checks parity and issues a soft_reset back to the FIFO if the destination stalls beyond a timeout.

Parameters:
TIMEOUT, 30, consecutive stalled cycles (pkt_valid=1, dst_ready=0) before the packet is abandoned
TO_W, 5, timeout counter width; must hold TIMEOUT

Ports:
clock  in  1  single clock, rising edge
resetn  in  1  reset, synchronous, active-low
fifo_empty  in  1  FIFO empty flag (registered in FIFO)
fifo_data  in  8  FIFO data_out; valid the cycle after read_enb
read_enb  out  1  FIFO read strobe
pkt_data  out  8  byte to destination
pkt_valid  out  1  pkt_data valid
dst_ready  in  1  destination accepts byte when pkt_valid && dst_ready
pkt_sop  out  1  pkt_data is the header
pkt_eop  out  1  pkt_data is the parity byte
parity_err  out  1  1-cycle pulse on parity-byte accept if mismatch
soft_reset  out  1  1-cycle pulse on timeout, to FIFO soft_reset

Behaviour:
- Packet format: header[7:2] = payload length L (0..63), header[1:0] = address (passed through). Then L payload bytes, then 1 parity byte. Total L+2 bytes.
- Parity rule: XOR of header and all payload bytes must equal the parity byte.
- Reset (resetn=0 at clock edge): state IDLE; all outputs 0 (pkt_data=8'h00); internal counters and parity accumulator 0. Any in-flight packet is dropped with no eop. Reset overrides every other event.

State machine:
- IDLE:
  - If !fifo_empty: read_enb=1 this cycle, mark next byte as header, go CAP.
- CAP (fifo_data valid):
  - Register fifo_data into pkt_data and set pkt_valid=1.
  - If the byte is the header: rem = L+1, par = byte, pkt_sop=1.
  - Else if rem==1: it is the parity byte, pkt_eop=1.
  - Else: par ^= byte.
  - Go HOLD.
- HOLD:
  - pkt_data, pkt_sop and pkt_eop are stable while pkt_valid && !dst_ready.
  - On accept of a non-eop byte: rem--, clear pkt_valid/sop. If !fifo_empty, read_enb=1 in the same cycle and go CAP; else go WAIT.
  - On accept of the eop byte: parity_err = (par != byte) for 1 cycle, clear pkt_valid/eop, go IDLE.
- WAIT (mid-packet, FIFO empty):
  - When !fifo_empty: read_enb=1, go CAP.
  - No timeout in WAIT.

Throughput and latency:
- Peak rate is 1 byte per 2 cycles.
- Latency: fifo_empty falls at cycle N -> read_enb at N -> pkt_valid at N+2.

Handshake and FIFO rules:
- read_enb is never asserted while fifo_empty=1.
- read_enb is never asserted while a byte is held unaccepted. This is the single-byte buffer rule.

Timeout:
- to_cnt increments each cycle in HOLD with !dst_ready.
- to_cnt clears on accept or on leaving HOLD.
- When to_cnt reaches TIMEOUT-1 and dst_ready=0: on the next edge soft_reset=1 for exactly 1 cycle, pkt_valid/sop/eop=0, no parity_err, state IDLE.
- The byte is discarded.
- dst_ready=1 on the cycle the counter hits the limit counts as an accept, and no timeout occurs.

Boundary conditions:
- L=0: header then parity; rem=1 after header.
- L=63: rem=64 (7-bit counter).
- Back-to-back packets: the eop accept returns to IDLE; the next header read starts the following cycle if !fifo_empty.
- Header with L inconsistent with FIFO contents: the block trusts L and waits in WAIT indefinitely.

Decomposition:
- Shared package router_pkg:
  - state enum {IDLE, CAP, HOLD, WAIT}
  - LEN_MSB=7, LEN_LSB=2
  - DEFAULT_TIMEOUT=30
- One natural sub-module: router_pkt_timeout, a stall counter with pulse output that is reusable by the other two egress ports.
- Parity accumulator and FSM stay in the top.

Test Plan:
- Single packet, dst_ready=1 throughout: FIFO holds 8'h09, 8'hAA, 8'h55, 8'hF6 -> pkt_data 09 (sop), AA, 55, F6 (eop) at 2-cycle spacing. parity_err stays 0; soft_reset stays 0.
- Same packet with last byte 8'hF7 -> parity_err pulses 1 cycle exactly at the eop accept.
- L=0 packet 8'h02, 8'h02 -> sop on byte 0, eop on byte 1, parity OK, return to IDLE.
- dst_ready=0 for 10 cycles on payload AA -> pkt_data held at AA, read_enb=0 throughout. Then accept; packet completes normally.
- dst_ready held 0 on header -> soft_reset pulses once after 30 stalled cycles, pkt_valid drops to 0, state IDLE.
- FIFO goes empty after header 8'h0C (L=3) -> WAIT with read_enb=0. Bytes refilled later -> remaining bytes delivered with correct eop.
- resetn=0 mid-payload -> next cycle all outputs 0. A new header is then processed as sop.

Source files
------------

// File: rtl/router_pkg.sv
// Shared types and constants for the router egress packet readers.
package router_pkg;

  typedef enum logic [1:0] {IDLE, CAP, HOLD, WAIT} state_t;

  localparam int LEN_MSB         = 7;
  localparam int LEN_LSB         = 2;
  localparam int LEN_W           = LEN_MSB - LEN_LSB + 1;
  localparam int REM_W           = LEN_W + 1;
  localparam int DEFAULT_TIMEOUT = 30;

  // Bytes still to arrive after the header: L payload bytes plus the parity byte.
  function automatic logic [REM_W-1:0] hdr_rem(input logic [LEN_W-1:0] len);
    return REM_W'(len) + REM_W'(1);
  endfunction

endpackage

// File: rtl/router_pkt_timeout.sv
// Destination stall watchdog: counts consecutive stalled cycles and emits a
// one-cycle pulse when the limit is reached. Shared by all egress readers.
module router_pkt_timeout
  import router_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  parameter int TO_W    = 5
) (
  input  logic clock,
  input  logic resetn,
  input  logic stall,
  output logic fire,
  output logic soft_reset
);

  logic [TO_W-1:0] to_cnt;

  // fire is combinational so the reader can abandon the byte on the same edge
  // that raises soft_reset.
  assign fire = stall && (to_cnt == TO_W'(TIMEOUT - 1));

  // NOTE: reset is synchronous (sampled only on the clock edge), and all
  // sequential state uses non-blocking assignments so every flop updates from
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      to_cnt     <= '0;
      soft_reset <= 1'b0;
    end else begin
      soft_reset <= fire;
      if (!stall || fire) begin
        to_cnt <= '0;
      end else begin
        to_cnt <= to_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/router_pkt_reader.sv
// Egress reader for one router output FIFO: pops bytes one at a time, frames
// them into header/payload/parity, and hands each byte out with valid/ready.
module router_pkt_reader
  import router_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  parameter int TO_W    = 5
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_data,
  output logic       read_enb,
  output logic [7:0] pkt_data,
  output logic       pkt_valid,
  input  logic       dst_ready,
  output logic       pkt_sop,
  output logic       pkt_eop,
  output logic       parity_err,
  output logic       soft_reset
);

  state_t           state, state_nxt;
  logic [REM_W-1:0] rem, rem_nxt;
  logic [7:0]       par, par_nxt;
  logic [7:0]       data_nxt;
  logic             hdr_flag, hdr_nxt;
  logic             valid_nxt, sop_nxt, eop_nxt, perr_nxt;
  logic             rd_req;
  logic             stall;
  logic             to_fire;

  // pkt_valid is always set in HOLD, so HOLD && dst_ready is the accept.
  assign stall    = (state == HOLD) && !dst_ready;
  assign read_enb = rd_req && resetn;

  router_pkt_timeout #(
    .TIMEOUT (TIMEOUT),
    .TO_W    (TO_W)
  ) u_timeout (
    .clock      (clock),
    .resetn     (resetn),
    .stall      (stall),
    .fire       (to_fire),
    .soft_reset (soft_reset)
  );

  always_ff @(posedge clock) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // NOTE: every signal driven here gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    rd_req    = 1'b0;
    rem_nxt   = rem;
    par_nxt   = par;
    hdr_nxt   = hdr_flag;
    data_nxt  = pkt_data;
    valid_nxt = pkt_valid;
    sop_nxt   = pkt_sop;
    eop_nxt   = pkt_eop;
    perr_nxt  = 1'b0;

    unique case (state)
      IDLE: begin
        if (!fifo_empty) begin
          rd_req    = 1'b1;
          hdr_nxt   = 1'b1;
          state_nxt = CAP;
        end
      end

      CAP: begin
        data_nxt  = fifo_data;
        valid_nxt = 1'b1;
        hdr_nxt   = 1'b0;
        sop_nxt   = 1'b0;
        eop_nxt   = 1'b0;
        if (hdr_flag) begin
          rem_nxt = hdr_rem(fifo_data[LEN_MSB:LEN_LSB]);
          par_nxt = fifo_data;
          sop_nxt = 1'b1;
        end else if (rem == REM_W'(1)) begin
          eop_nxt = 1'b1;
        end else begin
          par_nxt = par ^ fifo_data;
        end
        state_nxt = HOLD;
      end

      HOLD: begin
        if (to_fire) begin
          valid_nxt = 1'b0;
          sop_nxt   = 1'b0;
          eop_nxt   = 1'b0;
          rem_nxt   = '0;
          par_nxt   = '0;
          state_nxt = IDLE;
        end else if (dst_ready) begin
          valid_nxt = 1'b0;
          sop_nxt   = 1'b0;
          eop_nxt   = 1'b0;
          if (pkt_eop) begin
            perr_nxt  = (par != pkt_data);
            state_nxt = IDLE;
          end else begin
            // rem counts bytes after the header, so only payload accepts consume it.
            if (!pkt_sop) rem_nxt = rem - 1'b1;
            if (!fifo_empty) begin
              rd_req    = 1'b1;
              state_nxt = CAP;
            end else begin
              state_nxt = WAIT;
            end
          end
        end
      end

      WAIT: begin
        if (!fifo_empty) begin
          rd_req    = 1'b1;
          state_nxt = CAP;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      rem        <= '0;
      par        <= '0;
      hdr_flag   <= 1'b0;
      pkt_data   <= 8'h00;
      pkt_valid  <= 1'b0;
      pkt_sop    <= 1'b0;
      pkt_eop    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      rem        <= rem_nxt;
      par        <= par_nxt;
      hdr_flag   <= hdr_nxt;
      pkt_data   <= data_nxt;
      pkt_valid  <= valid_nxt;
      pkt_sop    <= sop_nxt;
      pkt_eop    <= eop_nxt;
      parity_err <= perr_nxt;
    end
  end

endmodule

// File: tb/tb_router_pkt_reader.sv
// Directed bench for router_pkt_reader with a behavioural FIFO and a
// destination whose ready line is driven step by step.
module tb_router_pkt_reader;

  logic       clock = 1'b0;
  logic       resetn;
  logic       fifo_empty;
  logic [7:0] fifo_data;
  logic       read_enb;
  logic [7:0] pkt_data;
  logic       pkt_valid;
  logic       dst_ready;
  logic       pkt_sop;
  logic       pkt_eop;
  logic       parity_err;
  logic       soft_reset;

  int         total = 0;
  int         bad   = 0;
  logic [7:0] q[$];

  always #5 clock = ~clock;

  router_pkt_reader #(
    .TIMEOUT (30),
    .TO_W    (5)
  ) dut (
    .clock      (clock),
    .resetn     (resetn),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .read_enb   (read_enb),
    .pkt_data   (pkt_data),
    .pkt_valid  (pkt_valid),
    .dst_ready  (dst_ready),
    .pkt_sop    (pkt_sop),
    .pkt_eop    (pkt_eop),
    .parity_err (parity_err),
    .soft_reset (soft_reset)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample read_enb mid-cycle, then model the FIFO pop at the edge.
  task automatic tick();
    logic re;
    #4;
    re = read_enb;
    check("rd_while_empty", 32'(re & fifo_empty), 32'd0);
    check("rd_while_held", 32'(re & pkt_valid & !dst_ready), 32'd0);
    @(posedge clock);
    #1;
    if (re && q.size() > 0) fifo_data = q.pop_front();
    fifo_empty = (q.size() == 0);
  endtask

  // Bytes are given MSB-first in a packed word.
  task automatic push(input logic [63:0] b, input int n);
    for (int i = 0; i < n; i++) q.push_back(b[8*(n-1-i) +: 8]);
    fifo_empty = 1'b0;
  endtask

  task automatic get_byte(input string tag, input logic [7:0] d, input logic sop,
                          input logic eop, input int lat);
    int n = 0;
    while (!pkt_valid && n < 8) begin
      tick();
      n++;
    end
    check({tag, "_valid"}, 32'(pkt_valid), 32'd1);
    check({tag, "_data"}, 32'(pkt_data), 32'(d));
    check({tag, "_sop"}, 32'(pkt_sop), 32'(sop));
    check({tag, "_eop"}, 32'(pkt_eop), 32'(eop));
    if (lat != 0) check({tag, "_lat"}, 32'(n), 32'(lat));
  endtask

  task automatic accept();
    dst_ready = 1'b1;
    tick();
  endtask

  task automatic run_pkt(input string tag, input logic [63:0] b, input int n,
                         input logic perr, input int first_lat);
    dst_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      get_byte($sformatf("%s_b%0d", tag, i), b[8*(n-1-i) +: 8], (i == 0), (i == n - 1),
               (i == 0) ? first_lat : 1);
      accept();
    end
    check({tag, "_perr"}, 32'(parity_err), 32'(perr));
    check({tag, "_valid_done"}, 32'(pkt_valid), 32'd0);
    check({tag, "_softrst"}, 32'(soft_reset), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    resetn     = 1'b0;
    fifo_empty = 1'b1;
    fifo_data  = 8'h00;
    dst_ready  = 1'b0;
    repeat (3) tick();
    check("rst_valid", 32'(pkt_valid), 32'd0);
    check("rst_data", 32'(pkt_data), 32'h00);
    check("rst_sop", 32'(pkt_sop), 32'd0);
    check("rst_eop", 32'(pkt_eop), 32'd0);
    check("rst_perr", 32'(parity_err), 32'd0);
    check("rst_softrst", 32'(soft_reset), 32'd0);
    check("rst_rd", 32'(read_enb), 32'd0);
    resetn = 1'b1;
    tick();

    // Good packet followed back-to-back by the same packet with a bad parity byte.
    push(64'h09AA55F6_09AA55F7, 8);
    run_pkt("t1", 64'h09AA55F6, 4, 1'b0, 2);
    #1;
    check("b2b_rd", 32'(read_enb), 32'd1);
    tick();
    check("t1_perr_clear", 32'(parity_err), 32'd0);
    run_pkt("t2", 64'h09AA55F7, 4, 1'b1, 1);
    tick();
    check("t2_perr_pulse", 32'(parity_err), 32'd0);

    // Zero-length payload.
    push(64'h0202, 2);
    run_pkt("t3", 64'h0202, 2, 1'b0, 2);
    tick();
    check("t3_idle_valid", 32'(pkt_valid), 32'd0);
    check("t3_idle_rd", 32'(read_enb), 32'd0);

    // Destination stall of 10 cycles on a payload byte.
    push(64'h09AA55F6, 4);
    dst_ready = 1'b1;
    get_byte("t4_hdr", 8'h09, 1'b1, 1'b0, 2);
    accept();
    dst_ready = 1'b0;
    get_byte("t4_aa", 8'hAA, 1'b0, 1'b0, 1);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t4_hold_data", 32'(pkt_data), 32'hAA);
      check("t4_hold_valid", 32'(pkt_valid), 32'd1);
      check("t4_hold_rd", 32'(read_enb), 32'd0);
    end
    accept();
    get_byte("t4_55", 8'h55, 1'b0, 1'b0, 1);
    accept();
    get_byte("t4_par", 8'hF6, 1'b0, 1'b1, 1);
    accept();
    check("t4_perr", 32'(parity_err), 32'd0);
    tick();

    // Header never accepted: timeout after 30 stalled cycles.
    push(64'h09, 1);
    dst_ready = 1'b0;
    get_byte("t5_hdr", 8'h09, 1'b1, 1'b0, 2);
    for (int i = 1; i < 30; i++) begin
      tick();
      check("t5_no_to_yet", 32'(soft_reset), 32'd0);
      check("t5_still_valid", 32'(pkt_valid), 32'd1);
    end
    tick();
    check("t5_softrst", 32'(soft_reset), 32'd1);
    check("t5_valid_drop", 32'(pkt_valid), 32'd0);
    check("t5_sop_drop", 32'(pkt_sop), 32'd0);
    check("t5_no_perr", 32'(parity_err), 32'd0);
    tick();
    check("t5_softrst_pulse", 32'(soft_reset), 32'd0);
    check("t5_idle_rd", 32'(read_enb), 32'd0);

    // Ready arrives on the very cycle the counter hits its limit: accept, no timeout.
    push(64'h0202, 2);
    get_byte("t5b_hdr", 8'h02, 1'b1, 1'b0, 2);
    for (int i = 1; i < 30; i++) tick();
    dst_ready = 1'b1;
    tick();
    check("t5b_no_softrst", 32'(soft_reset), 32'd0);
    check("t5b_accepted", 32'(pkt_valid), 32'd0);
    get_byte("t5b_par", 8'h02, 1'b0, 1'b1, 1);
    accept();
    check("t5b_perr", 32'(parity_err), 32'd0);
    tick();
    check("t5b_softrst_late", 32'(soft_reset), 32'd0);

    // FIFO runs dry after the header (L=3): wait, then finish on refill.
    push(64'h0C, 1);
    dst_ready = 1'b1;
    get_byte("t6_hdr", 8'h0C, 1'b1, 1'b0, 2);
    accept();
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t6_wait_rd", 32'(read_enb), 32'd0);
      check("t6_wait_valid", 32'(pkt_valid), 32'd0);
    end
    push(64'h1122330C, 4);
    get_byte("t6_11", 8'h11, 1'b0, 1'b0, 2);
    accept();
    get_byte("t6_22", 8'h22, 1'b0, 1'b0, 1);
    accept();
    get_byte("t6_33", 8'h33, 1'b0, 1'b0, 1);
    accept();
    get_byte("t6_par", 8'h0C, 1'b0, 1'b1, 1);
    accept();
    check("t6_perr", 32'(parity_err), 32'd0);
    tick();

    // Reset in the middle of a payload, then a fresh packet.
    push(64'h09AA55F6, 4);
    dst_ready = 1'b1;
    get_byte("t7_hdr", 8'h09, 1'b1, 1'b0, 2);
    accept();
    dst_ready = 1'b0;
    get_byte("t7_aa", 8'hAA, 1'b0, 1'b0, 1);
    resetn = 1'b0;
    tick();
    check("t7_rst_valid", 32'(pkt_valid), 32'd0);
    check("t7_rst_data", 32'(pkt_data), 32'h00);
    check("t7_rst_sop", 32'(pkt_sop), 32'd0);
    check("t7_rst_eop", 32'(pkt_eop), 32'd0);
    check("t7_rst_rd", 32'(read_enb), 32'd0);
    q.delete();
    fifo_empty = 1'b1;
    tick();
    resetn = 1'b1;
    push(64'h0202, 2);
    run_pkt("t7", 64'h0202, 2, 1'b0, 2);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
